spmem_cam: RTL and testbench

Synthesizable sparse memory: a fully-associative store of `DEPTH` address/data entries over an `ADDR_W`-bit address space, returning `DEFAULT_DATA` for any address never written. It replaces the behavioural sparse model wherever the design needs real RTL. It adds byte strobes, entry deallocation, global clear, occupancy reporting and overflow signalling. It drives the same chip-select, read and write port style as the existing sparse-memory interface, plus new handshake and status outputs.

---
 rtl/spmem_cam_pkg.sv | 15 +
 rtl/spmem_cam_alloc.sv | 28 ++
 rtl/spmem_cam.sv | 173 +++++++++++++++++
 tb/tb_spmem_cam.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmem_cam_pkg.sv
// Shared defaults and entry layout for the
// fully-associative sparse memory.
package spmem_cam_pkg;

   localparam int SPMEM_ADDR_W = 32;
   localparam int SPMEM_DATA_W = 32;
   localparam int SPMEM_DEPTH  = 16;

   typedef struct packed {
      logic                    valid;
      logic [SPMEM_ADDR_W-1:0] tag;
      logic [SPMEM_DATA_W-1:0] data;
   } spmem_entry_t;

endpackage

// File: rtl/spmem_cam_alloc.sv
// Lowest-index free entry picker: one-hot grant
// plus a flag telling whether any entry is free.
module spmem_cam_alloc
   import spmem_cam_pkg::*;
#(
   parameter int DEPTH = SPMEM_DEPTH
) (
   input  logic [DEPTH-1:0] valid_i,
   output logic [DEPTH-1:0] grant_o,
   output logic             any_free_o
);

   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_i[i] && !found) begin
            grant_o[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any_free_o = found;

endmodule

// File: rtl/spmem_cam.sv
// Fully-associative sparse memory with byte strobes,
// free, clear, occupancy and overflow reporting.
module spmem_cam
   import spmem_cam_pkg::*;
#(
   parameter int                ADDR_W       = SPMEM_ADDR_W,
   parameter int                DATA_W       = SPMEM_DATA_W,
   parameter int                DEPTH        = SPMEM_DEPTH,
   parameter logic [DATA_W-1:0] DEFAULT_DATA = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cs_ni,
   input  logic                       we_i,
   input  logic                       re_i,
   input  logic                       free_i,
   input  logic                       clear_i,
   input  logic [ADDR_W-1:0]          write_address_i,
   input  logic [DATA_W-1:0]          write_data_i,
   input  logic [DATA_W/8-1:0]        write_strb_i,
   input  logic [ADDR_W-1:0]          read_address_i,
   output logic [DATA_W-1:0]          read_data_o,
   output logic                       read_valid_o,
   output logic                       read_hit_o,
   output logic                       write_drop_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int IDX_W  = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q;
   logic [ADDR_W-1:0] tag_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [DEPTH-1:0] whit_vec;
   logic [DEPTH-1:0] rhit_vec;
   logic [DEPTH-1:0] grant;
   logic             any_free;
   logic             w_hit;
   logic             r_hit;
   logic [IDX_W-1:0] ridx;

   logic do_read;
   logic do_clear;
   logic do_write;
   logic do_alloc;
   logic do_drop;
   logic do_free;

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              full_q;
   logic              drop_q;
   logic              s1_valid;
   logic              s1_hit;
   logic [DATA_W-1:0] s1_data;
   logic              rd_valid_q;
   logic              rd_hit_q;
   logic [DATA_W-1:0] rd_data_q;

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] base,
      input logic [DATA_W-1:0] wdata,
      input logic [STRB_W-1:0] strb
   );
      logic [DATA_W-1:0] res;
      res = base;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      end
      return res;
   endfunction

   // Tags are unique among valid entries, so both vectors are one-hot or zero
   always_comb begin
      whit_vec = '0;
      rhit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         whit_vec[i] = valid_q[i] && (tag_q[i] == write_address_i);
         rhit_vec[i] = valid_q[i] && (tag_q[i] == read_address_i);
      end
   end

   always_comb begin
      ridx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rhit_vec[i]) ridx = IDX_W'(i);
      end
   end

   assign w_hit = |whit_vec;
   assign r_hit = |rhit_vec;

   spmem_cam_alloc #(
      .DEPTH (DEPTH)
   ) u_alloc (
      .valid_i    (valid_q),
      .grant_o    (grant),
      .any_free_o (any_free)
   );

   assign do_read  = !cs_ni && re_i;
   assign do_clear = !cs_ni && clear_i;
   assign do_write = !cs_ni && we_i && !clear_i;
   assign do_alloc = do_write && !w_hit && any_free;
   assign do_drop  = do_write && !w_hit && !any_free;
   assign do_free  = !cs_ni && free_i && !we_i
                     && !clear_i && w_hit;

   always_comb begin
      count_d = count_q;
      if (do_clear)      count_d = '0;
      else if (do_alloc) count_d = count_q + 1'b1;
      else if (do_free)  count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         drop_q     <= 1'b0;
         s1_valid   <= 1'b0;
         s1_hit     <= 1'b0;
         s1_data    <= '0;
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         count_q  <= count_d;
         full_q   <= (count_d == CNT_W'(DEPTH));
         drop_q   <= do_drop;
         s1_valid <= do_read;
         // Lookup at the request edge gives read-before-write
         if (do_read) begin
            s1_hit  <= r_hit;
            s1_data <= r_hit ? data_q[ridx] : DEFAULT_DATA;
         end
         rd_valid_q <= s1_valid;
         if (s1_valid) begin
            rd_hit_q  <= s1_hit;
            rd_data_q <= s1_data;
         end
         if (do_clear)      valid_q <= '0;
         else if (do_free)  valid_q <= valid_q & ~whit_vec;
         else if (do_alloc) valid_q <= valid_q | grant;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst_i && do_alloc && grant[i]) begin
            tag_q[i]  <= write_address_i;
            data_q[i] <= merge(DEFAULT_DATA, write_data_i,
                               write_strb_i);
         end else if (!rst_i && do_write && whit_vec[i]) begin
            data_q[i] <= merge(data_q[i], write_data_i,
                               write_strb_i);
         end
      end
   end

   assign read_data_o  = rd_data_q;
   assign read_valid_o = rd_valid_q;
   assign read_hit_o   = rd_hit_q;
   assign write_drop_o = drop_q;
   assign full_o       = full_q;
   assign count_o      = count_q;

endmodule

// File: tb/tb_spmem_cam.sv
// Randomised and directed bench for spmem_cam
// against an associative-array reference model.
module tb_spmem_cam;

   localparam int          DEPTH = 16;
   localparam logic [31:0] DEF   = 32'h0;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cs_ni;
   logic        we_i;
   logic        re_i;
   logic        free_i;
   logic        clear_i;
   logic [31:0] write_address_i;
   logic [31:0] write_data_i;
   logic [3:0]  write_strb_i;
   logic [31:0] read_address_i;
   logic [31:0] read_data_o;
   logic        read_valid_o;
   logic        read_hit_o;
   logic        write_drop_o;
   logic        full_o;
   logic [4:0]  count_o;

   always #5 clk_i = ~clk_i;

   spmem_cam dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .cs_ni           (cs_ni),
      .we_i            (we_i),
      .re_i            (re_i),
      .free_i          (free_i),
      .clear_i         (clear_i),
      .write_address_i (write_address_i),
      .write_data_i    (write_data_i),
      .write_strb_i    (write_strb_i),
      .read_address_i  (read_address_i),
      .read_data_o     (read_data_o),
      .read_valid_o    (read_valid_o),
      .read_hit_o      (read_hit_o),
      .write_drop_o    (write_drop_o),
      .full_o          (full_o),
      .count_o         (count_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] base,
                                         input logic [31:0] wd,
                                         input logic [3:0]  st);
      logic [31:0] r;
      r = base;
      for (int b = 0; b < 4; b++)
         if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // Reference: address -> data map, at most DEPTH keys
   logic [31:0] mem [logic [31:0]];
   bit          s1v;
   bit          s1h;
   logic [31:0] s1d;
   bit          e_rvalid;
   bit          e_rhit;
   logic [31:0] e_rdata;
   bit          e_drop;
   int          e_count;
   bit          chk_en = 0;

   always @(posedge clk_i) begin
      if (rst_i) begin
         mem.delete();
         s1v      = 0;
         e_rvalid = 0;
         e_rhit   = 0;
         e_rdata  = 32'h0;
         e_drop   = 0;
         chk_en   = 1;
      end else begin
         e_rvalid = s1v;
         if (s1v) begin
            e_rdata = s1d;
            e_rhit  = s1h;
         end
         s1v    = 0;
         e_drop = 0;
         if (!cs_ni) begin
            if (re_i) begin
               s1v = 1;
               s1h = mem.exists(read_address_i);
               s1d = s1h ? mem[read_address_i] : DEF;
            end
            if (clear_i) begin
               mem.delete();
            end else if (we_i) begin
               if (mem.exists(write_address_i))
                  mem[write_address_i] = merge(mem[write_address_i],
                                               write_data_i, write_strb_i);
               else if (mem.num() < DEPTH)
                  mem[write_address_i] = merge(DEF, write_data_i,
                                               write_strb_i);
               else
                  e_drop = 1;
            end else if (free_i && mem.exists(write_address_i)) begin
               mem.delete(write_address_i);
            end
         end
      end
      e_count = mem.num();
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("read_valid", {31'b0, read_valid_o}, {31'b0, e_rvalid});
         check("read_hit", {31'b0, read_hit_o}, {31'b0, e_rhit});
         check("read_data", read_data_o, e_rdata);
         check("write_drop", {31'b0, write_drop_o}, {31'b0, e_drop});
         check("count", {27'b0, count_o}, e_count);
         check("full", {31'b0, full_o}, {31'b0, e_count == DEPTH});
      end
   end

   task automatic step(input bit rst, input bit csn, input bit we,
                       input bit re, input bit fr, input bit cl,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] ra);
      rst_i           = rst;
      cs_ni           = csn;
      we_i            = we;
      re_i            = re;
      free_i          = fr;
      clear_i         = cl;
      write_address_i = wa;
      write_data_i    = wd;
      write_strb_i    = st;
      read_address_i  = ra;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s);
      step(0, 0, 1, 0, 0, 0, a, d, s, 0);
   endtask

   task automatic rd(input logic [31:0] a);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, a);
   endtask

   initial begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("reset_count", {27'b0, count_o}, 32'd0);
      check("reset_rvalid", {31'b0, read_valid_o}, 32'd0);

      rd(32'h1000);
      idle();
      check("miss_rvalid", {31'b0, read_valid_o}, 32'd1);
      check("miss_hit", {31'b0, read_hit_o}, 32'd0);
      check("miss_data", read_data_o, DEF);

      wr(32'h1000, 32'hAABBCCDD, 4'hF);
      wr(32'h1000, 32'h11223344, 4'h3);
      rd(32'h1000);
      idle();
      check("strb_data", read_data_o, 32'hAABB3344);
      check("strb_hit", {31'b0, read_hit_o}, 32'd1);
      check("strb_count", {27'b0, count_o}, 32'd1);

      for (int i = 0; i < 15; i++)
         wr(32'h2000 + 32'(i * 4), 32'(i + 1), 4'hF);
      check("fill_full", {31'b0, full_o}, 32'd1);
      check("fill_count", {27'b0, count_o}, 32'd16);
      wr(32'h9000, 32'h55, 4'hF);
      check("drop_pulse", {31'b0, write_drop_o}, 32'd1);
      check("drop_count", {27'b0, count_o}, 32'd16);
      idle();
      check("drop_once", {31'b0, write_drop_o}, 32'd0);
      rd(32'h9000);
      idle();
      check("drop_miss", {31'b0, read_hit_o}, 32'd0);
      step(0, 0, 0, 0, 1, 0, 32'h2000, 0, 0, 0);
      check("free_count", {27'b0, count_o}, 32'd15);
      wr(32'h9000, 32'h55, 4'hF);
      rd(32'h9000);
      idle();
      check("retry_hit", {31'b0, read_hit_o}, 32'd1);
      check("retry_data", read_data_o, 32'h55);

      step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 32'h20, 32'h77, 4'hF, 32'h20);
      idle();
      check("rbw_valid", {31'b0, read_valid_o}, 32'd1);
      check("rbw_hit", {31'b0, read_hit_o}, 32'd0);
      check("rbw_data", read_data_o, DEF);
      rd(32'h20);
      idle();
      check("rbw_next_hit", {31'b0, read_hit_o}, 32'd1);
      check("rbw_next_data", read_data_o, 32'h77);

      step(0, 0, 1, 0, 0, 1, 32'h40, 32'h99, 4'hF, 0);
      check("clr_count", {27'b0, count_o}, 32'd0);
      rd(32'h40);
      idle();
      check("clr_miss", {31'b0, read_hit_o}, 32'd0);

      wr(32'h60, 32'h66, 4'hF);
      step(0, 1, 1, 1, 1, 1, 32'h60, 32'h0, 4'hF, 32'h60);
      idle();
      check("cs_rvalid", {31'b0, read_valid_o}, 32'd0);
      check("cs_count", {27'b0, count_o}, 32'd1);
      rd(32'h60);
      idle();
      check("cs_data", read_data_o, 32'h66);

      rd(32'h60);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_rvalid", {31'b0, read_valid_o}, 32'd0);
      check("rst_data", read_data_o, 32'd0);
      check("rst_count", {27'b0, count_o}, 32'd0);
      idle();
      check("rst_rvalid2", {31'b0, read_valid_o}, 32'd0);

      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 63) == 0,
              32'h100 + 32'($urandom_range(0, 19) * 4),
              $urandom,
              4'($urandom_range(0, 15)),
              32'h100 + 32'($urandom_range(0, 19) * 4));
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
